mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequences one load or store at a time between the pipeline's memory stage and a variable-latency data-memory port. On stores it generates byte enables and lane-shifted write data. On loads it selects the byte or halfword lane and applies sign or zero extension, using the load-extension mode encoding already used in the datapath. It detects misalignment, bounds the memory wait with a timeout, and returns exactly one response per accepted request.

## Interface
- ACK_TIMEOUT, 255: number of cycles in REQ without `mem_ack` before the access is aborted; range 1..1023.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_mode  in  3  size/extension mode:
  - 000 word.
  - 001 byte, signed.
  - 010 byte, unsigned.
  - 011 half, signed.
  - 100 half, unsigned.
  - 101–111 treated as word.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- mem_en  out  1  memory request strobe.
- mem_we  out  4  byte write enables; 0000 for loads.
- mem_addr  out  32  word address: `{req_addr[31:2], 2'b00}`.
- mem_wdata  out  32  lane-shifted store data.
- mem_ack  in  1  memory completed the access; `mem_rdata` valid in the same cycle.
- mem_rdata  in  32  read word.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  32  extended load result; 0 for stores and errors.
- resp_misalign  out  1  request was misaligned; no memory access made.
- resp_timeout  out  1  access aborted by timeout.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch we, mode, addr and wdata.
  - If misaligned, go to RESP with misalign set; otherwise go to REQ.
- Misalignment rules:
  - Word modes: `addr[1:0] != 0`.
  - Half modes: `addr[0] != 0`.
  - Byte modes: never misaligned.
- REQ:
  - `mem_en`, `mem_addr`, `mem_we` and `mem_wdata` are driven from the latched request and held stable.
  - On `mem_ack`, capture `mem_rdata` and go to RESP.
  - Otherwise increment the wait counter. When the counter reaches ACK_TIMEOUT, go to RESP with timeout set.
- RESP: `resp_valid` = 1 for exactly one cycle, then return to IDLE.
- Store lanes, with `off` = `addr[1:0]`:
  - Byte: `mem_we` = `0001 << off`; the byte is replicated on all four lanes.
  - Half: `mem_we` = `0011 << (2*addr[1])`; the half is replicated on both halves.
  - Word: `mem_we` = `1111`.
- Load select:
  - Byte = `rdata[8*off +: 8]`.
  - Half = `rdata[16*addr[1] +: 16]`.
  - Signed modes replicate bit 7 or bit 15 into the upper bits; unsigned modes zero-fill; word passes through.
- Response flags: `resp_misalign` and `resp_timeout` are mutually exclusive and are 0 on a normal completion.
- `mem_ack` is ignored in IDLE and RESP; stray or late acks have no effect.
- There is no response backpressure; the pipeline must consume `resp_valid` when it pulses.

## Timing
- Reset: state = IDLE; `mem_en` = 0, `mem_we` = 0, `resp_valid` = 0, `resp_misalign` = 0, `resp_timeout` = 0, `resp_data` = 0, wait counter = 0. `req_ready` = 1 from the first cycle after reset.
- Reset mid-access: reset in REQ drops `mem_en` at the next edge. No response is produced for the aborted request.
- Accept happens in cycle N: the edge that samples `req_valid` with `req_ready` high.
- Aligned access:
  - `mem_en` is high from cycle N+1.
  - If `mem_ack` arrives in cycle N+k (k ≥ 1), `resp_valid` is high in cycle N+k+1.
  - `req_ready` is high again in cycle N+k+2.
- Minimum load-to-response latency is 2 cycles.
- Misaligned access: `resp_valid` in cycle N+1; `mem_en` never asserts.
- Timeout: with no ack, `mem_en` is high for exactly ACK_TIMEOUT cycles, then `resp_valid` and `resp_timeout` pulse in the following cycle.
- An ack in the final permitted wait cycle counts as success, not timeout.
- All `mem_*` and `resp_*` outputs are registered.
- Back-to-back throughput: at most one request per k+2 cycles.

## Test plan
- Load byte signed: mode=001, addr=0x1003, ack after 3 cycles, rdata=0x80FF0000 -> mem_addr=0x1000, resp_data=0xFFFFFF80, resp_valid 4 cycles after accept.
- Load half unsigned vs signed: addr=0x2002, rdata=0x9ABC1234 -> mode 100 gives 0x00009ABC; mode 011 gives 0xFFFF9ABC.
- Store byte: mode=010, addr=0x3001, wdata=0x000000A5 -> mem_we=0010, mem_wdata=0xA5A5A5A5, resp_data=0.
- Misaligned word store: mode=000, addr=0x4002 -> resp_misalign=1 one cycle after accept, mem_en stays 0.
- Timeout with ACK_TIMEOUT=4 and mem_ack never asserted -> mem_en high 4 cycles, then resp_timeout pulse. A later ack while in IDLE is ignored and req_ready stays 1.
- Reset asserted during the 2nd REQ cycle -> mem_en=0 and req_ready=1 next cycle, no resp_valid. The next request completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding load/store sequencer with lane steering, misalign and ack timeout
module mem_access_ctrl #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_misalign,
    output logic        resp_timeout
);
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [2:0]        mode_q;
    logic [1:0]        off_q;
    logic              mem_en_q;
    logic [3:0]        mem_we_q;
    logic [31:0]       mem_addr_q, mem_wdata_q;
    logic              resp_valid_q, resp_misalign_q, resp_timeout_q;
    logic [31:0]       resp_data_q;

    logic              accept, misalign, ack_ok, tmo;
    logic              req_is_byte, req_is_half;
    logic [3:0]        lanes;
    logic [31:0]       wdata_rep;
    logic [31:0]       rd_shift, load_data;

    assign req_is_byte = (req_mode == 3'd1) || (req_mode == 3'd2);
    assign req_is_half = (req_mode == 3'd3) || (req_mode == 3'd4);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        misalign = 1'b0;
        ack_ok   = 1'b0;
        tmo      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_is_byte)      misalign = 1'b0;
                    else if (req_is_half) misalign = req_addr[0];
                    else                  misalign = (req_addr[1:0] != 2'b00);
                    state_d = misalign ? RESP : REQ;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                // An ack on the last permitted wait cycle wins over the timeout.
                if (mem_ack) begin
                    ack_ok  = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lanes     = 4'b0000;
        wdata_rep = req_wdata;
        if (req_is_byte) begin
            lanes     = 4'b0001 << req_addr[1:0];
            wdata_rep = {4{req_wdata[7:0]}};
        end else if (req_is_half) begin
            lanes     = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{req_wdata[15:0]}};
        end else begin
            lanes     = 4'b1111;
        end
        if (!req_we) lanes = 4'b0000;
    end

    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        case (mode_q)
            3'd1:    load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd2:    load_data = {24'b0, rd_shift[7:0]};
            3'd3:    load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    load_data = {16'b0, rd_shift[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            we_q            <= 1'b0;
            mode_q          <= 3'd0;
            off_q           <= 2'd0;
            mem_en_q        <= 1'b0;
            mem_we_q        <= 4'b0000;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            resp_valid_q    <= 1'b0;
            resp_misalign_q <= 1'b0;
            resp_timeout_q  <= 1'b0;
            resp_data_q     <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            mem_en_q        <= (state_d == REQ);
            resp_valid_q    <= (state_d == RESP);
            resp_misalign_q <= accept && misalign;
            resp_timeout_q  <= tmo;
            resp_data_q     <= (ack_ok && !we_q) ? load_data : 32'd0;
            if (accept) begin
                we_q        <= req_we;
                mode_q      <= req_mode;
                off_q       <= req_addr[1:0];
                mem_addr_q  <= {req_addr[31:2], 2'b00};
                mem_wdata_q <= wdata_rep;
                mem_we_q    <= misalign ? 4'b0000 : lanes;
            end else if (state_d != REQ) begin
                mem_we_q    <= 4'b0000;
            end
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign mem_en        = mem_en_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_misalign = resp_misalign_q;
    assign resp_timeout  = resp_timeout_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_mode;
    logic [31:0] req_addr, req_wdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_misalign, resp_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_misalign(resp_misalign), .resp_timeout(resp_timeout)
    );

    function automatic int sz(input logic [2:0] m);
        case (m)
            3'd1, 3'd2: return 1;
            3'd3, 3'd4: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] m, input logic [31:0] a, input logic [31:0] rd);
        int s = sz(m);
        logic [31:0] mask = (s == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * s)) - 32'h1);
        logic [31:0] v = (rd >> (8 * (a % 4))) & mask;
        if ((m == 3'd1 || m == 3'd3) && v[8 * s - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] m_we(input logic w, input logic [2:0] m, input logic [31:0] a);
        int s = sz(m);
        if (!w) return 4'b0000;
        return 4'(((1 << s) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] m, input logic [31:0] w);
        int s = sz(m);
        if (s == 1) return 32'(w[7:0]) * 32'h0101_0101;
        if (s == 2) return 32'(w[15:0]) * 32'h0001_0001;
        return w;
    endfunction

    // Drives one request and observes it; k = cycle of ack after accept (0 = never).
    task automatic run_access(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int k,
                              output int resp_c, output int en_cnt, output logic [3:0] o_we,
                              output logic [31:0] o_addr, output logic [31:0] o_wdata,
                              output logic stable, output logic [31:0] o_data,
                              output logic o_mis, output logic o_tmo,
                              output logic ready_after, output logic resp_again);
        req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = $urandom; req_addr = $urandom; req_wdata = $urandom;
        req_mode = 3'($urandom);
        resp_c = -1; en_cnt = 0; stable = 1'b1; o_we = 4'b0; o_addr = '0; o_wdata = '0;
        o_data = '0; o_mis = 1'b0; o_tmo = 1'b0; ready_after = 1'b0; resp_again = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            if (resp_c >= 0) begin
                ready_after = req_ready;
                resp_again  = resp_valid;
                break;
            end
            mem_ack   = (c == k);
            mem_rdata = (c == k) ? rdata : $urandom;
            if (mem_en) begin
                if (en_cnt == 0) begin
                    o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata;
                end else if (o_we !== mem_we || o_addr !== mem_addr || o_wdata !== mem_wdata) begin
                    stable = 1'b0;
                end
                en_cnt++;
            end
            if (resp_valid) begin
                resp_c = c; o_data = resp_data; o_mis = resp_misalign; o_tmo = resp_timeout;
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    int          rc, en;
    logic [3:0]  owe;
    logic [31:0] oaddr, owd, odata;
    logic        stab, omis, otmo, rdy, again;

    task automatic test_reset();
        n_tests++;
        if ({req_ready, mem_en, mem_we, resp_valid, resp_misalign, resp_timeout} !== 9'b1_0_0000_0_0_0) begin
            n_fail++;
            $display("FAIL reset_ctrl got rdy=%b en=%b we=%b rv=%b mis=%b tmo=%b want 1 0 0000 0 0 0",
                     req_ready, mem_en, mem_we, resp_valid, resp_misalign, resp_timeout);
        end
        n_tests++;
        if (resp_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_data got %h want 0", resp_data);
        end
    endtask

    task automatic test_load_byte_signed();
        run_access(1'b0, 3'd1, 32'h1003, 32'h0, 32'h80FF_0000, 3, rc, en, owe, oaddr, owd, stab, odata, omis, otmo, rdy, again);
        n_tests++;
        if (rc !== 4) begin n_fail++; $display("FAIL lb_latency got %0d want 4", rc); end
        n_tests++;
        if (oaddr !== 32'h1000) begin n_fail++; $display("FAIL lb_addr got %h want 00001000", oaddr); end
        n_tests++;
        if (odata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data got %h want ffffff80", odata); end
        n_tests++;
        if (owe !== 4'b0000 || en !== 3) begin n_fail++; $display("FAIL lb_mem got we=%b en=%0d want 0000 3", owe, en); end
    endtask

    task automatic test_load_half();
        run_access(1'b0, 3'd4, 32'h2002, 32'h0, 32'h9ABC_1234, 1, rc, en, owe, oaddr, owd, stab, odata, omis, otmo, rdy, again);
        n_tests++;
        if (odata !== 32'h0000_9ABC || rc !== 2) begin
            n_fail++; $display("FAIL lhu got %h lat %0d want 00009abc lat 2", odata, rc);
        end
        run_access(1'b0, 3'd3, 32'h2002, 32'h0, 32'h9ABC_1234, 1, rc, en, owe, oaddr, owd, stab, odata, omis, otmo, rdy, again);
        n_tests++;
        if (odata !== 32'hFFFF_9ABC) begin n_fail++; $display("FAIL lh got %h want ffff9abc", odata); end
    endtask

    task automatic test_store_byte();
        run_access(1'b1, 3'd2, 32'h3001, 32'h0000_00A5, 32'hDEAD_BEEF, 2, rc, en, owe, oaddr, owd, stab, odata, omis, otmo, rdy, again);
        n_tests++;
        if (owe !== 4'b0010 || owd !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL sb_lanes got we=%b wd=%h want 0010 a5a5a5a5", owe, owd);
        end
        n_tests++;
        if (odata !== 32'd0 || omis !== 1'b0 || otmo !== 1'b0) begin
            n_fail++; $display("FAIL sb_resp got d=%h mis=%b tmo=%b want 0 0 0", odata, omis, otmo);
        end
    endtask

    task automatic test_misalign();
        run_access(1'b1, 3'd0, 32'h4002, 32'h1234_5678, 32'h0, 1, rc, en, owe, oaddr, owd, stab, odata, omis, otmo, rdy, again);
        n_tests++;
        if (rc !== 1 || omis !== 1'b1 || otmo !== 1'b0 || en !== 0) begin
            n_fail++; $display("FAIL misalign got lat=%0d mis=%b tmo=%b en=%0d want 1 1 0 0", rc, omis, otmo, en);
        end
    endtask

    task automatic test_timeout();
        int bad = 0;
        run_access(1'b0, 3'd0, 32'h5000, 32'h0, 32'h0, 0, rc, en, owe, oaddr, owd, stab, odata, omis, otmo, rdy, again);
        n_tests++;
        if (en !== T || rc !== T + 1 || otmo !== 1'b1 || omis !== 1'b0 || odata !== 32'd0) begin
            n_fail++; $display("FAIL timeout got en=%0d lat=%0d tmo=%b mis=%b d=%h want %0d %0d 1 0 0",
                               en, rc, otmo, omis, odata, T, T + 1);
        end
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            if (!req_ready || resp_valid || mem_en) bad++;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        if (!req_ready || resp_valid || mem_en) bad++;
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL stray_ack got %0d bad cycles want 0", bad); end
        run_access(1'b0, 3'd2, 32'h5003, 32'h0, 32'h7700_0000, T, rc, en, owe, oaddr, owd, stab, odata, omis, otmo, rdy, again);
        n_tests++;
        if (otmo !== 1'b0 || rc !== T + 1 || odata !== 32'h0000_0077) begin
            n_fail++; $display("FAIL last_cycle_ack got tmo=%b lat=%0d d=%h want 0 %0d 00000077", otmo, rc, odata, T + 1);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        req_we = 1'b0; req_mode = 3'd0; req_addr = 32'h6000; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (mem_en !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid got en=%b rdy=%b rv=%b want 0 1 0", mem_en, req_ready, resp_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ack = (i == 1);
            if (resp_valid || mem_en) bad++;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL reset_mid_quiet got %0d bad cycles want 0", bad); end
        run_access(1'b0, 3'd0, 32'h6004, 32'h0, 32'hCAFE_F00D, 2, rc, en, owe, oaddr, owd, stab, odata, omis, otmo, rdy, again);
        n_tests++;
        if (odata !== 32'hCAFE_F00D || rc !== 3 || !rdy) begin
            n_fail++; $display("FAIL after_reset got d=%h lat=%0d rdy=%b want cafef00d 3 1", odata, rc, rdy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic        we    = 1'($urandom);
            logic [2:0]  mode  = 3'($urandom_range(0, 7));
            logic [31:0] addr  = $urandom;
            logic [31:0] wdata = $urandom;
            logic [31:0] rdata = $urandom;
            int          k     = $urandom_range(0, T + 1);
            logic        mis   = (addr % sz(mode)) != 0;
            logic        ok    = !mis && k >= 1 && k <= T;
            int          e_rc  = mis ? 1 : (ok ? k + 1 : T + 1);
            int          e_en  = mis ? 0 : (ok ? k : T);
            logic [31:0] e_d   = (ok && !we) ? m_load(mode, addr, rdata) : 32'd0;
            run_access(we, mode, addr, wdata, rdata, k, rc, en, owe, oaddr, owd, stab, odata, omis, otmo, rdy, again);
            n_tests++;
            if (rc !== e_rc || en !== e_en || omis !== mis || otmo !== (!mis && !ok) || !rdy || again) begin
                n_fail++;
                $display("FAIL rnd_ctl[%0d] got lat=%0d en=%0d mis=%b tmo=%b rdy=%b rv2=%b want %0d %0d %b %b 1 0",
                         i, rc, en, omis, otmo, rdy, again, e_rc, e_en, mis, !mis && !ok);
            end
            n_tests++;
            if (odata !== e_d) begin n_fail++; $display("FAIL rnd_data[%0d] got %h want %h", i, odata, e_d); end
            if (!mis) begin
                n_tests++;
                if (owe !== m_we(we, mode, addr) || oaddr !== {addr[31:2], 2'b00} || !stab ||
                    (we && owd !== m_wdata(mode, wdata))) begin
                    n_fail++;
                    $display("FAIL rnd_mem[%0d] got we=%b a=%h wd=%h stable=%b want %b %h %h 1", i, owe, oaddr, owd,
                             stab, m_we(we, mode, addr), {addr[31:2], 2'b00}, m_wdata(mode, wdata));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 3'd3, 32'h7002, 32'h0000_BEEF, 32'h0, 1, rc, en, owe, oaddr, owd, stab, odata, omis, otmo, rdy, again);
        n_tests++;
        if (owe !== 4'b1100 || owd !== 32'hBEEF_BEEF || !rdy) begin
            n_fail++; $display("FAIL b2b_store got we=%b wd=%h rdy=%b want 1100 beefbeef 1", owe, owd, rdy);
        end
        run_access(1'b0, 3'd0, 32'h7000, 32'h0, 32'h0102_0304, 1, rc, en, owe, oaddr, owd, stab, odata, omis, otmo, rdy, again);
        n_tests++;
        if (odata !== 32'h0102_0304 || rc !== 2) begin
            n_fail++; $display("FAIL b2b_load got d=%h lat=%0d want 01020304 2", odata, rc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mode = 3'd0; req_addr = '0; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_load_byte_signed();
        test_load_half();
        test_store_byte();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
